// File: rtl/uart_txr.sv
// 8N1 UART transmitter: one start bit, eight data bits LSB first, one stop bit,
// each held CLKS_PER_BIT clocks, followed by a one-cycle completion pulse.
module uart_txr #(
  parameter int unsigned CLKS_PER_BIT = 10
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_byte_to_send,
  input  logic       i_data_valid,
  output logic       o_dataline,
  output logic       o_send_complete
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] clk_cnt;
  logic [CNT_W-1:0] clk_cnt_nxt;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_nxt;
  logic [7:0]       shift_reg;
  logic [7:0]       shift_nxt;
  logic             armed;
  logic             armed_nxt;
  logic             dataline_nxt;
  logic             complete_nxt;
  logic             bit_end;
  logic             accept;

  assign bit_end = (clk_cnt == CNT_LAST);
  assign accept  = (state == S_IDLE) && i_data_valid && armed;

  // State and datapath registers; reset wins over everything on the same edge
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state           <= S_IDLE;
      clk_cnt         <= '0;
      bit_idx         <= '0;
      shift_reg       <= '0;
      armed           <= 1'b1;
      o_dataline      <= 1'b1;
      o_send_complete <= 1'b0;
    end else begin
      state           <= state_nxt;
      clk_cnt         <= clk_cnt_nxt;
      bit_idx         <= bit_idx_nxt;
      shift_reg       <= shift_nxt;
      armed           <= armed_nxt;
      o_dataline      <= dataline_nxt;
      o_send_complete <= complete_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_START;
      S_START: if (bit_end) state_nxt = S_DATA;
      S_DATA:  if (bit_end && (bit_idx == 3'd7)) state_nxt = S_STOP;
      S_STOP:  if (bit_end) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values for the registered outputs and datapath
  always_comb begin
    dataline_nxt = o_dataline;
    complete_nxt = 1'b0;
    clk_cnt_nxt  = '0;
    bit_idx_nxt  = bit_idx;
    shift_nxt    = shift_reg;

    // A low request re-arms; a held request cannot launch a second frame
    if (!i_data_valid) begin
      armed_nxt = 1'b1;
    end else if (accept) begin
      armed_nxt = 1'b0;
    end else begin
      armed_nxt = armed;
    end

    case (state)
      S_IDLE: begin
        dataline_nxt = 1'b1;
        if (accept) begin
          shift_nxt    = i_byte_to_send;
          dataline_nxt = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          bit_idx_nxt  = 3'd0;
          dataline_nxt = shift_reg[0];
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            dataline_nxt = 1'b1;
          end else begin
            bit_idx_nxt  = bit_idx + 3'd1;
            dataline_nxt = shift_reg[bit_idx + 3'd1];
          end
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end
      S_STOP: begin
        dataline_nxt = 1'b1;
        if (bit_end) begin
          complete_nxt = 1'b1;
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end
      S_DONE: begin
        dataline_nxt = 1'b1;
      end
      default: begin
        dataline_nxt = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_txr.sv
// Self-checking bench for uart_txr: a line monitor checks every frame cycle by
// cycle against bytes queued by the stimulus driver.
module tb_uart_txr;

  localparam int CPB = 10;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [7:0] i_byte_to_send;
  logic       i_data_valid;
  logic       o_dataline;
  logic       o_send_complete;

  typedef struct {
    logic [7:0] data;
    bit         b2b;
  } sb_t;

  sb_t sb_q[$];
  int  n_chk = 0;
  int  n_bad = 0;
  int  cyc = 0;
  int  last_done = 0;
  int  n_pulse = 0;
  int  exp_pulses = 0;
  bit  abort_req = 1'b0;

  uart_txr #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_byte_to_send  (i_byte_to_send),
    .i_data_valid    (i_data_valid),
    .o_dataline      (o_dataline),
    .o_send_complete (o_send_complete)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) if (o_send_complete === 1'b1) n_pulse <= n_pulse + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic exp_line(input logic [7:0] d, input int slot);
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return d[3'(slot - 1)];
  endfunction

  // Waits for the completion pulse, returning just after the edge that raised it
  task automatic wait_done();
    for (int i = 0; i < 3000; i++) begin
      @(posedge i_clk);
      #1;
      if (o_send_complete === 1'b1) return;
    end
    check("done_timeout", o_send_complete, 1);
  endtask

  // Line monitor: a low line outside reset marks the start cycle of a frame
  initial begin : monitor
    sb_t e;
    int  s;
    forever begin
      @(negedge i_clk);
      if (i_rst === 1'b0 && o_dataline === 1'b0) begin
        s = cyc;
        if (sb_q.size() == 0) begin
          check("unexpected_frame", o_dataline, 1);
          repeat (10 * CPB) @(negedge i_clk);
        end else begin
          e = sb_q.pop_front();
          if (e.b2b) check("b2b_gap", s - last_done, 2);
          for (int t = 0; t < 10 * CPB + 2; t++) begin
            if (t > 0) @(negedge i_clk);
            if (abort_req) begin
              abort_req = 1'b0;
              break;
            end
            if (t < 10 * CPB) begin
              check("frame_line", o_dataline, exp_line(e.data, t / CPB));
              check("busy_complete", o_send_complete, 0);
            end else if (t == 10 * CPB) begin
              check("done_pulse", o_send_complete, 1);
              check("done_line", o_dataline, 1);
              last_done = cyc;
            end else begin
              check("post_pulse", o_send_complete, 0);
              check("post_line", o_dataline, 1);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int p0;
    i_rst          = 1'b1;
    i_data_valid   = 1'b0;
    i_byte_to_send = 8'h00;
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 50; i++) begin
      @(negedge i_clk);
      check("idle_line", o_dataline, 1);
      check("idle_complete", o_send_complete, 0);
    end

    // Single frame, request dropped on the completion pulse
    @(posedge i_clk); #1;
    sb_q.push_back('{data: 8'h55, b2b: 1'b0});
    i_byte_to_send = 8'h55;
    i_data_valid   = 1'b1;
    wait_done();
    i_data_valid = 1'b0;
    exp_pulses++;
    repeat (20) @(posedge i_clk); #1;

    // Held request transmits exactly once
    sb_q.push_back('{data: 8'hA3, b2b: 1'b0});
    i_byte_to_send = 8'hA3;
    i_data_valid   = 1'b1;
    repeat (300) @(posedge i_clk); #1;
    check("held_line_high", o_dataline, 1);
    i_data_valid = 1'b0;
    exp_pulses++;
    repeat (20) @(posedge i_clk); #1;

    // Byte and request change mid-frame do not disturb the frame
    sb_q.push_back('{data: 8'h0F, b2b: 1'b0});
    i_byte_to_send = 8'h0F;
    i_data_valid   = 1'b1;
    repeat (26) @(posedge i_clk); #1;
    i_byte_to_send = 8'hF0;
    i_data_valid   = 1'b0;
    wait_done();
    exp_pulses++;
    repeat (20) @(posedge i_clk); #1;

    // Back-to-back: drop in the DONE cycle, reassert on the next
    sb_q.push_back('{data: 8'h3C, b2b: 1'b0});
    sb_q.push_back('{data: 8'h81, b2b: 1'b1});
    i_byte_to_send = 8'h3C;
    i_data_valid   = 1'b1;
    wait_done();
    i_data_valid = 1'b0;
    @(posedge i_clk); #1;
    i_byte_to_send = 8'h81;
    i_data_valid   = 1'b1;
    wait_done();
    i_data_valid = 1'b0;
    exp_pulses += 2;
    repeat (20) @(posedge i_clk); #1;

    // Reset in the middle of a frame
    sb_q.push_back('{data: 8'h99, b2b: 1'b0});
    i_byte_to_send = 8'h99;
    i_data_valid   = 1'b1;
    repeat (46) @(posedge i_clk); #1;
    abort_req    = 1'b1;
    i_rst        = 1'b1;
    i_data_valid = 1'b0;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    check("rst_line", o_dataline, 1);
    check("rst_complete", o_send_complete, 0);
    p0 = n_pulse;
    for (int i = 0; i < 120; i++) begin
      @(negedge i_clk);
      check("post_rst_line", o_dataline, 1);
    end
    check("post_rst_no_pulse", n_pulse, p0);

    // Full frame after the aborted one
    @(posedge i_clk); #1;
    sb_q.push_back('{data: 8'hC6, b2b: 1'b0});
    i_byte_to_send = 8'hC6;
    i_data_valid   = 1'b1;
    wait_done();
    i_data_valid = 1'b0;
    exp_pulses++;
    repeat (20) @(posedge i_clk); #1;

    check("pulse_count", n_pulse, exp_pulses);
    check("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
